// File: rtl/audio_pkg.sv
// Shared constants and FSM encoding for the microphone conditioning path.
package audio_pkg;

  localparam int IN_W_DEF  = 12;
  localparam int OUT_W_DEF = 24;

  // Offset-binary zero point of the 12-bit microphone code.
  localparam logic [IN_W_DEF-1:0] MIDSCALE = 12'h800;

  // Saturation limits for the default output width.
  localparam logic [OUT_W_DEF-1:0] OUT_MAX = 24'h7FFFFF;
  localparam logic [OUT_W_DEF-1:0] OUT_MIN = 24'h800000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SAT  = 2'd2
  } state_e;

endpackage

// File: rtl/mic_peak_meter.sv
// Peak-hold level meter: instant attack, one-step decay every DECAY_DIV outputs.
module mic_peak_meter
  import audio_pkg::*;
#(
  parameter int OUT_W     = OUT_W_DEF,
  parameter int DECAY_DIV = 256
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [OUT_W-1:0] sample,
  input  logic             strobe,
  output logic [7:0]       level
);

  localparam int CNT_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  logic [OUT_W-1:0] mag_raw, mag, thr;
  logic [7:0]       cand, level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wrap, capture;

  // Magnitude of the sample; |-2^(OUT_W-1)| does not fit, so pin it to the max.
  always_comb begin
    mag_raw = sample[OUT_W-1] ? (~sample + 1'b1) : sample;
    mag     = mag_raw[OUT_W-1] ? {1'b0, {(OUT_W-1){1'b1}}} : mag_raw;
    cand    = mag[OUT_W-2 -: 8];
    // cand > level is the same as mag reaching the next level step; comparing
    // the full magnitude against that step keeps the low bits meaningful.
    thr     = {({1'b0, level_q} + 9'd1), {(OUT_W-9){1'b0}}};
    capture = (mag >= thr);
    wrap    = (cnt_q == CNT_W'(DECAY_DIV - 1));
  end

  // Capture beats decay; the decay counter advances on every output sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
      cnt_q   <= '0;
    end else if (strobe) begin
      if (capture)
        level_q <= cand;
      else if (wrap && level_q != 8'd0)
        level_q <= level_q - 8'd1;
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/mic_dc_block.sv
// Offset-binary mic samples -> signed, DC-removed, saturated I2S-width audio.
module mic_dc_block
  import audio_pkg::*;
#(
  parameter int IN_W       = IN_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int POLE_SHIFT = 8,
  parameter int DECAY_DIV  = 256
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_wr,
  input  logic             bypass,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  output logic [7:0]       level,
  output logic             overrun
);

  // Three guard bits cover x - x_prev + y_prev without wrap.
  localparam int ACC_W = OUT_W + 3;
  localparam logic [IN_W-1:0] MID = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] LIM_HI = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] LIM_LO = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_e                  state_q, state_d;
  logic                    busy_wr;
  logic signed [OUT_W-1:0] x_in, x_q, x_prev_q, y_prev_q, sat_val;
  logic signed [ACC_W-1:0] xe, xpe, ype, acc_d, acc_q;
  logic                    byp_q;
  logic [OUT_W-1:0]        out_data_q;
  logic                    out_valid_q, overrun_q;

  // Flipping the MSB turns offset binary into two's complement; left-align to OUT_W.
  assign x_in = {in_data ^ MID, {(OUT_W-IN_W){1'b0}}};

  // Next state; any write that arrives while a sample is in flight is a drop.
  always_comb begin
    state_d = state_q;
    busy_wr = 1'b0;
    unique case (state_q)
      ST_IDLE: if (in_wr) state_d = ST_CALC;
      ST_CALC: begin
        state_d = ST_SAT;
        busy_wr = in_wr;
      end
      ST_SAT: begin
        state_d = ST_IDLE;
        busy_wr = in_wr;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Leaky-integrator high-pass: y = x - x_prev + y_prev*(1 - 2^-POLE_SHIFT), then clip.
  always_comb begin
    xe    = {{(ACC_W-OUT_W){x_q[OUT_W-1]}}, x_q};
    xpe   = {{(ACC_W-OUT_W){x_prev_q[OUT_W-1]}}, x_prev_q};
    ype   = {{(ACC_W-OUT_W){y_prev_q[OUT_W-1]}}, y_prev_q};
    acc_d = bypass ? xe : (xe - xpe + ype - (ype >>> POLE_SHIFT));
    if (acc_q > LIM_HI)
      sat_val = LIM_HI[OUT_W-1:0];
    else if (acc_q < LIM_LO)
      sat_val = LIM_LO[OUT_W-1:0];
    else
      sat_val = acc_q[OUT_W-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Filter datapath: capture in IDLE, accumulate in CALC, clip and publish in SAT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q         <= '0;
      x_prev_q    <= '0;
      y_prev_q    <= '0;
      acc_q       <= '0;
      byp_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      overrun_q   <= overrun_q | busy_wr;
      unique case (state_q)
        ST_IDLE: if (in_wr) x_q <= x_in;
        ST_CALC: begin
          acc_q    <= acc_d;
          x_prev_q <= x_q;
          byp_q    <= bypass;
        end
        ST_SAT: begin
          out_data_q  <= sat_val;
          // Bypassed samples must not seed the feedback path.
          y_prev_q    <= byp_q ? '0 : sat_val;
          out_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  mic_peak_meter #(
    .OUT_W     (OUT_W),
    .DECAY_DIV (DECAY_DIV)
  ) u_meter (
    .clk    (clk),
    .rst    (rst),
    .sample (out_data_q),
    .strobe (out_valid_q),
    .level  (level)
  );

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mic_dc_block.sv
// Directed + randomized bench for mic_dc_block against an arithmetic reference model.
module tb_mic_dc_block;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] in_data;
  logic        in_wr;
  logic        bypass;
  logic [23:0] out_data;
  logic        out_valid;
  logic [7:0]  level;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  longint m_xp, m_yp;
  int     m_lvl, m_cnt;

  always #5 clk = ~clk;

  mic_dc_block #(
    .IN_W(12), .OUT_W(24), .POLE_SHIFT(8), .DECAY_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_wr(in_wr), .bypass(bypass),
    .out_data(out_data), .out_valid(out_valid), .level(level), .overrun(overrun)
  );

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_xp = 0; m_yp = 0; m_lvl = 0; m_cnt = 0;
  endtask

  // One output sample: y = x - x_prev + y_prev - floor(y_prev/256), clipped to 24 bits.
  function automatic longint model_step(input logic [11:0] d, input logic byp);
    longint x, acc, y, mag;
    int     cand;
    x   = (longint'(d) - 2048) * 4096;
    acc = byp ? x : (x - m_xp + m_yp - (m_yp >>> 8));
    y   = (acc > 64'sd8388607) ? 64'sd8388607 : (acc < -64'sd8388608) ? -64'sd8388608 : acc;
    m_xp = x;
    m_yp = byp ? 0 : y;
    mag  = (y < 0) ? -y : y;
    if (mag > 8388607) mag = 8388607;
    cand = int'(mag / 32768);
    if (cand > m_lvl) m_lvl = cand;
    else if (m_cnt == 3 && m_lvl > 0) m_lvl = m_lvl - 1;
    m_cnt = (m_cnt + 1) % 4;
    return y;
  endfunction

  // Issue one sample and verify the k+3 latency, the data and the meter.
  task automatic send(input logic [11:0] d, input logic byp, input string tag);
    longint     y;
    logic [23:0] e;
    in_data = d; bypass = byp; in_wr = 1'b1;
    y = model_step(d, byp);
    e = y[23:0];
    tick(); in_wr = 1'b0;
    check({tag, " vld k+1"}, out_valid, 0);
    tick();
    check({tag, " vld k+2"}, out_valid, 0);
    tick();
    check({tag, " vld k+3"}, out_valid, 1);
    check({tag, " data"}, out_data, e);
    tick();
    check({tag, " vld k+4"}, out_valid, 0);
    check({tag, " level"}, level, m_lvl);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0; in_wr = 1'b0;
    #1;
    check({tag, " data"}, out_data, 0);
    check({tag, " vld"}, out_valid, 0);
    check({tag, " level"}, level, 0);
    check({tag, " ovr"}, overrun, 0);
    tick();
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [23:0] prev;
    rst = 1'b0; in_wr = 1'b0; bypass = 1'b0; in_data = MIDSCALE;
    model_reset();

    // Writes during reset are ignored.
    for (int i = 0; i < 4; i++) begin
      in_wr = 1'b1; in_data = 12'($urandom);
      tick();
      check("rst data", out_data, 0);
      check("rst vld", out_valid, 0);
      check("rst level", level, 0);
      check("rst ovr", overrun, 0);
    end
    in_wr = 1'b0;
    rst = 1'b1;
    tick();

    // Bypass extremes.
    send(12'hFFF, 1'b1, "byp max");
    check("byp max const", out_data, 32'h7FF000);
    send(12'h000, 1'b1, "byp min");
    check("byp min const", out_data, 32'h800000);

    // Reset in the middle of CALC: outputs drop at once, nothing emerges later.
    in_data = 12'hABC; bypass = 1'b0; in_wr = 1'b1;
    tick(); in_wr = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst data", out_data, 0);
    check("midrst vld", out_valid, 0);
    check("midrst level", level, 0);
    check("midrst ovr", overrun, 0);
    tick(); rst = 1'b1; model_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst no vld", out_valid, 0);
    end

    // DC step response and slow decay; meter captures 0x80 then leaks.
    send(12'h800, 1'b0, "dc0");
    check("dc0 const", out_data, 32'h000000);
    send(12'hC00, 1'b0, "dc1");
    check("dc1 const", out_data, 32'h400000);
    check("dc1 level const", level, 32'h80);
    send(12'hC00, 1'b0, "dc2");
    check("dc2 const", out_data, 32'h3FC000);
    prev = out_data;
    for (int i = 0; i < 6; i++) begin
      send(12'hC00, 1'b0, "dc tail");
      check("dc monotone", (out_data < prev) && !out_data[23], 1);
      prev = out_data;
    end
    for (int i = 0; i < 12; i++) send(12'h800, 1'b0, "meter decay");

    // Saturation at both rails.
    do_reset("rst2");
    send(12'h000, 1'b0, "sat lo");
    check("sat lo const", out_data, 32'h800000);
    send(12'hFFF, 1'b0, "sat hi");
    check("sat hi const", out_data, 32'h7FFFFF);

    // Back-to-back writes: second dropped, overrun sticks.
    begin
      longint     y;
      logic [23:0] e;
      in_data = 12'h9A0; bypass = 1'b0; in_wr = 1'b1;
      y = model_step(12'h9A0, 1'b0); e = y[23:0];
      tick();
      in_data = 12'($urandom);
      check("ovr k+1", overrun, 0);
      tick(); in_wr = 1'b0;
      check("ovr k+2", overrun, 1);
      check("ovr vld k+2", out_valid, 0);
      tick();
      check("ovr vld k+3", out_valid, 1);
      check("ovr data", out_data, e);
      tick();
      check("ovr vld k+4", out_valid, 0);
      check("ovr sticky", overrun, 1);
      check("ovr level", level, m_lvl);
    end

    // A write in the SAT cycle is dropped too.
    begin
      longint     y;
      logic [23:0] e;
      in_data = 12'h5F0; in_wr = 1'b1;
      y = model_step(12'h5F0, 1'b0); e = y[23:0];
      tick(); in_wr = 1'b0;
      tick(); in_wr = 1'b1; in_data = 12'($urandom);
      tick(); in_wr = 1'b0;
      check("satdrop vld", out_valid, 1);
      check("satdrop data", out_data, e);
      for (int i = 0; i < 3; i++) begin
        tick();
        check("satdrop no vld", out_valid, 0);
      end
    end
    send(12'h700, 1'b0, "post ovr");

    // Randomized samples, occasional bypass, random idle gaps.
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
        check("rand idle vld", out_valid, 0);
      end
      send(12'($urandom), ($urandom_range(0, 4) == 0), "rand");
      check("rand ovr", overrun, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic_dc_block.md
Name: mic_dc_block

Overview:
- Audio conditioning stage between the PmodMIC3 SPI receiver and the PmodI2S transmitter.
- Accepts 12-bit offset-binary microphone samples on a write strobe, converts them to signed values, and removes DC with a first-order leaky IIR high-pass filter.
- Produces saturated signed 24-bit samples ready for the I2S data_l/data_r inputs, plus an 8-bit peak-level meter with slow decay for the board LEDs.

Parameters:
- IN_W, 12: input sample width, offset binary.
- OUT_W, 24: output sample width, two's complement.
- POLE_SHIFT, 8: feedback leak shift; pole a = 1 - 2^-POLE_SHIFT (about 30 Hz corner at 48 kHz).
- DECAY_DIV, 256: number of output samples between one-step decrements of the peak meter.

Ports:
- clk, input, 1: system clock, 98.304 MHz.
- rst, input, 1: asynchronous, active-low reset.
- in_data, input, IN_W: microphone sample, offset binary (0x800 = zero).
- in_wr, input, 1: one-cycle strobe; in_data is valid in that cycle.
- bypass, input, 1: 1 = skip the filter and pass the scaled input through.
- out_data, output, OUT_W: filtered sample; held until the next update.
- out_valid, output, 1: one-cycle pulse when out_data updates.
- level, output, 8: peak magnitude meter.
- overrun, output, 1: sticky flag; set when a sample is dropped.

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately, including mid-computation):
  - out_data=0, out_valid=0, level=0, overrun=0.
  - state=IDLE; x_prev=0, y_prev=0; decay counter=0.
  - in_wr is ignored while rst is low.
- Input scaling: x = signed(in_data ^ 0x800) << (OUT_W-IN_W). Range is -0x800000 to 0x7FF000.
- FSM states IDLE, CALC, SAT:
  - IDLE: when in_wr=1, capture x and go to CALC; otherwise stay.
  - CALC (1 cycle), internal accumulator width OUT_W+3:
    - acc <= x - x_prev + y_prev - (y_prev >>> POLE_SHIFT), using arithmetic shift.
    - If bypass=1: acc <= x.
    - x_prev <= x. Go to SAT.
  - SAT (1 cycle):
    - Clip acc to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
    - out_data <= clipped value; y_prev <= clipped value (set to 0 when bypass=1).
    - out_valid <= 1 for exactly one cycle. Go to IDLE.
- Latency: in_wr high in cycle k gives out_valid high in cycle k+3 with the new out_data. At most one sample can be in flight.
- in_wr while in CALC or SAT: the sample is dropped, overrun <= 1, and the in-flight computation is not disturbed. overrun clears only on reset.
- in_wr in the same cycle the FSM returns to IDLE (state SAT) counts as busy and is dropped.
- bypass is sampled in CALC. Toggling it causes a one-sample transient only; no other side effect.
- Peak meter, updated in the cycle out_valid is asserted:
  - mag = |out_data|, clipped to 2^(OUT_W-1)-1; cand = mag[OUT_W-2 -: 8].
  - If cand > level: level <= cand.
  - Otherwise, when the decay counter wraps at DECAY_DIV-1 and level > 0: level <= level-1.
  - The decay counter increments on every output, modulo DECAY_DIV.
  - A capture has priority over a decrement in the same sample.

Decomposition:
- Shared package audio_pkg holds:
  - IN_W/OUT_W defaults.
  - Midscale constant 0x800.
  - Saturation limits OUT_MAX/OUT_MIN.
  - FSM state encoding (IDLE=0, CALC=1, SAT=2).
- One sub-module, mic_peak_meter: inputs clk, rst, sample, strobe; output level. Holds the magnitude, capture and decay-counter logic.
- The filter datapath and FSM stay in mic_dc_block.

Test Plan:
- Reset: drive in_wr pulses while rst=0 -> out_data=0, out_valid=0, level=0, overrun=0 throughout. Assert rst mid-CALC -> outputs return to 0 immediately and no out_valid follows.
- Bypass: bypass=1, in_data=0xFFF in cycle k -> out_valid only in cycle k+3, out_data=0x7FF000. Then in_data=0x000 -> out_data=0x800000.
- DC step: bypass=0 after reset, send 0x800, then 0xC00 twice -> outputs 0x000000, 0x400000, 0x3FC000. Continued 0xC00 decays monotonically toward 0.
- Saturation: after reset, send 0x000, then 0xFFF -> first out_data=0x800000 (-2^23), second 0x7FFFFF (unclipped 0x807000).
- Overrun: in_wr high in cycles k and k+1 -> exactly one out_valid (cycle k+3), overrun=1 from cycle k+2 and staying set. Next isolated in_wr processes normally.
- Peak meter (DECAY_DIV=4): DC-step sequence -> level=0x80 after the 0x400000 output. Then feed 0x800 samples -> level decrements by 1 every 4 outputs and never goes below the cand of the current output.
